// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/divide unit: operation codes, FSM states
// and the most-negative 32-bit integer used by the signed-divide overflow rule.
package mdu_pkg;

  localparam logic [3:0] MdOpNone  = 4'd0;
  localparam logic [3:0] MdOpMult  = 4'd1;
  localparam logic [3:0] MdOpMultu = 4'd2;
  localparam logic [3:0] MdOpDiv   = 4'd3;
  localparam logic [3:0] MdOpDivu  = 4'd4;
  localparam logic [3:0] MdOpMthi  = 4'd5;
  localparam logic [3:0] MdOpMtlo  = 4'd6;
  localparam logic [3:0] MdOpMfhi  = 4'd7;
  localparam logic [3:0] MdOpMflo  = 4'd8;

  localparam logic [31:0] IntMin = 32'h8000_0000;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_compute.sv
// Combinational multiply/divide datapath. Produces the HI/LO pair for the
// presented op and flags divides whose divisor is zero.
module mdu_compute
  import mdu_pkg::*;
(
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_by_zero
);

  logic signed [63:0] a_ext;
  logic signed [63:0] b_ext;
  logic [63:0]        prod_s;
  logic [63:0]        prod_u;

  logic        rt_zero;
  logic [31:0] divisor;
  logic [31:0] quo_u;
  logic [31:0] rem_u;
  logic [31:0] abs_a;
  logic [31:0] abs_b;
  logic [31:0] quo_mag;
  logic [31:0] rem_mag;
  logic [31:0] quo_s;
  logic [31:0] rem_s;
  logic        div_ovf;

  assign a_ext  = {{32{rs_val[31]}}, rs_val};
  assign b_ext  = {{32{rt_val[31]}}, rt_val};
  assign prod_s = a_ext * b_ext;
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Divide by a safe non-zero value so the datapath never produces X; the
  // result is discarded by the controller when the divisor is zero.
  assign rt_zero = (rt_val == 32'd0);
  assign divisor = rt_zero ? 32'd1 : rt_val;
  assign quo_u   = rs_val / divisor;
  assign rem_u   = rs_val % divisor;

  // Signed divide on magnitudes; IntMin's magnitude is representable unsigned.
  assign abs_a   = rs_val[31] ? (32'd0 - rs_val) : rs_val;
  assign abs_b   = divisor[31] ? (32'd0 - divisor) : divisor;
  assign quo_mag = abs_a / abs_b;
  assign rem_mag = abs_a % abs_b;
  assign div_ovf = (rs_val == IntMin) && (rt_val == 32'hFFFF_FFFF);

  always_comb begin
    if (div_ovf) begin
      quo_s = IntMin;
      rem_s = 32'd0;
    end else begin
      quo_s = (rs_val[31] ^ divisor[31]) ? (32'd0 - quo_mag) : quo_mag;
      rem_s = rs_val[31] ? (32'd0 - rem_mag) : rem_mag;
    end
  end

  always_comb begin
    res_hi      = 32'd0;
    res_lo      = 32'd0;
    div_by_zero = 1'b0;
    case (md_op)
      MdOpMult: begin
        res_hi = prod_s[63:32];
        res_lo = prod_s[31:0];
      end
      MdOpMultu: begin
        res_hi = prod_u[63:32];
        res_lo = prod_u[31:0];
      end
      MdOpDiv: begin
        res_hi      = rem_s;
        res_lo      = quo_s;
        div_by_zero = rt_zero;
      end
      MdOpDivu: begin
        res_hi      = rem_u;
        res_lo      = quo_u;
        div_by_zero = rt_zero;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mdu_ctrl.sv
// Execute-stage multiply/divide controller: owns HI/LO, models fixed
// multiply/divide latency with a busy window and requests stalls meanwhile.
module mdu_ctrl
  import mdu_pkg::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        busy,
  output logic        stall_req,
  output logic [31:0] rd_val,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int unsigned CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam logic [CntW-1:0] MultLoad = CntW'(MULT_CYCLES - 1);
  localparam logic [CntW-1:0] DivLoad  = CntW'(DIV_CYCLES - 1);

  mdu_state_e      state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]     pend_hi_q, pend_hi_d;
  logic [31:0]     pend_lo_q, pend_lo_d;
  logic            pend_wr_q, pend_wr_d;
  logic [31:0]     hi_q, hi_d;
  logic [31:0]     lo_q, lo_d;

  logic        is_md;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div_by_zero;

  mdu_compute u_compute (
    .md_op       (md_op),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .res_hi      (res_hi),
    .res_lo      (res_lo),
    .div_by_zero (div_by_zero)
  );

  assign is_md     = op_valid && (md_op >= MdOpMult) && (md_op <= MdOpMflo);
  assign busy      = (state_q == StBusy);
  assign stall_req = is_md && busy;
  assign hi        = hi_q;
  assign lo        = lo_q;

  always_comb begin
    rd_val = 32'd0;
    if (op_valid && md_op == MdOpMfhi) begin
      rd_val = hi_q;
    end else if (op_valid && md_op == MdOpMflo) begin
      rd_val = lo_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_wr_d = pend_wr_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      StIdle: begin
        // In idle every MDU op is accepted, since busy is low.
        if (is_md) begin
          case (md_op)
            MdOpMult, MdOpMultu: begin
              pend_hi_d = res_hi;
              pend_lo_d = res_lo;
              pend_wr_d = 1'b1;
              cnt_d     = MultLoad;
              state_d   = StBusy;
            end
            MdOpDiv, MdOpDivu: begin
              pend_hi_d = res_hi;
              pend_lo_d = res_lo;
              pend_wr_d = !div_by_zero;
              cnt_d     = DivLoad;
              state_d   = StBusy;
            end
            MdOpMthi: hi_d = rs_val;
            MdOpMtlo: lo_d = rs_val;
            default: ;
          endcase
        end
      end
      StBusy: begin
        if (cnt_q == '0) begin
          state_d = StIdle;
          if (pend_wr_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      pend_hi_q <= 32'd0;
      pend_lo_q <= 32'd0;
      pend_wr_q <= 1'b0;
      hi_q      <= 32'd0;
      lo_q      <= 32'd0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_wr_q <= pend_wr_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

endmodule

// File: tb/tb_mdu_ctrl.sv
// Bench for mdu_ctrl: directed scenarios plus random ops, compared cycle by
// cycle against an arithmetic model of HI/LO and the remaining busy time.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int unsigned MultCycles = 5;
  localparam int unsigned DivCycles  = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        op_valid = 1'b0;
  logic [3:0]  md_op = 4'd0;
  logic [31:0] rs_val = 32'd0;
  logic [31:0] rt_val = 32'd0;
  logic        busy;
  logic        stall_req;
  logic [31:0] rd_val;
  logic [31:0] hi;
  logic [31:0] lo;

  int errors = 0;
  int checks = 0;

  // Model: architectural HI/LO, cycles of busy left, and the result to commit.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  bit          m_pwr;
  int          m_rem;

  mdu_ctrl #(
    .MULT_CYCLES (MultCycles),
    .DIV_CYCLES  (DivCycles)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .op_valid  (op_valid),
    .md_op     (md_op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .busy      (busy),
    .stall_req (stall_req),
    .rd_val    (rd_val),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_hi  = 32'd0;
    m_lo  = 32'd0;
    m_phi = 32'd0;
    m_plo = 32'd0;
    m_pwr = 1'b0;
    m_rem = 0;
  endfunction

  function automatic void model_accept(input logic [3:0] op, input logic [31:0] a,
                                       input logic [31:0] b);
    longint      sa, sb, sp, sq, sr;
    logic [63:0] up;
    logic [63:0] tmp;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      MdOpMult: begin
        sp = sa * sb;
        tmp = 64'(sp);
        m_phi = tmp[63:32]; m_plo = tmp[31:0]; m_pwr = 1'b1; m_rem = MultCycles;
      end
      MdOpMultu: begin
        up = {32'd0, a} * {32'd0, b};
        m_phi = up[63:32]; m_plo = up[31:0]; m_pwr = 1'b1; m_rem = MultCycles;
      end
      MdOpDiv: begin
        m_rem = DivCycles;
        m_pwr = (b != 32'd0);
        if (m_pwr) begin
          sq = sa / sb;
          sr = sa % sb;
          tmp = 64'(sq); m_plo = tmp[31:0];
          tmp = 64'(sr); m_phi = tmp[31:0];
        end
      end
      MdOpDivu: begin
        m_rem = DivCycles;
        m_pwr = (b != 32'd0);
        if (m_pwr) begin
          m_plo = a / b;
          m_phi = a % b;
        end
      end
      MdOpMthi: m_hi = a;
      MdOpMtlo: m_lo = a;
      default: ;
    endcase
  endfunction

  // One clock cycle: drive at negedge, compare, then advance the model at posedge.
  task automatic step(input logic v, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] b);
    bit          is_md;
    logic [31:0] exp_rd;
    @(negedge clk);
    op_valid = v;
    md_op    = op;
    rs_val   = a;
    rt_val   = b;
    #1;
    is_md = v && (op >= 4'd1) && (op <= 4'd8);
    check_eq("busy", 32'(busy), 32'(m_rem > 0));
    check_eq("stall_req", 32'(stall_req), 32'(is_md && (m_rem > 0)));
    check_eq("hi", hi, m_hi);
    check_eq("lo", lo, m_lo);
    if (v && !(is_md && m_rem > 0)) begin
      exp_rd = (op == MdOpMfhi) ? m_hi : (op == MdOpMflo) ? m_lo : 32'd0;
      check_eq("rd_val", rd_val, exp_rd);
    end
    @(posedge clk);
    if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && m_pwr) begin
        m_hi = m_phi;
        m_lo = m_plo;
      end
    end else if (is_md) begin
      model_accept(op, a, b);
    end
  endtask

  task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    step(1'b1, op, a, b);
    for (int i = 0; i < 20 && m_rem > 0; i++) step(1'b1, MdOpNone, $urandom, $urandom);
  endtask

  function automatic logic [31:0] rnd_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return IntMin;
      2: return 32'hFFFF_FFFF;
      3: return 32'd1;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    model_reset();
    #1;
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_stall", 32'(stall_req), 32'd0);
    check_eq("rst_rd", rd_val, 32'd0);
    check_eq("rst_hi", hi, 32'd0);
    check_eq("rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // MULT then MFLO held while stalled; first unstalled MFLO sees new LO.
    step(1'b1, MdOpMult, 32'hFFFF_FFFF, 32'd2);
    for (int i = 0; i < MultCycles; i++) begin
      step(1'b1, MdOpMflo, 32'd0, 32'd0);
      check_eq("mflo_stalled", 32'(stall_req), 32'd1);
    end
    step(1'b1, MdOpMflo, 32'd0, 32'd0);
    check_eq("mflo_new", rd_val, 32'hFFFF_FFFE);
    check_eq("mult_hi", hi, 32'hFFFF_FFFF);
    check_eq("mult_lo", lo, 32'hFFFF_FFFE);

    run_op(MdOpMultu, 32'hFFFF_FFFF, 32'd2);
    step(1'b0, MdOpNone, 32'd0, 32'd0);
    check_eq("multu_hi", hi, 32'd1);
    check_eq("multu_lo", lo, 32'hFFFF_FFFE);

    run_op(MdOpDiv, 32'hFFFF_FFF9, 32'd2);
    step(1'b0, MdOpNone, 32'd0, 32'd0);
    check_eq("div_lo", lo, 32'hFFFF_FFFD);
    check_eq("div_hi", hi, 32'hFFFF_FFFF);

    run_op(MdOpDiv, IntMin, 32'hFFFF_FFFF);
    step(1'b0, MdOpNone, 32'd0, 32'd0);
    check_eq("ovf_lo", lo, IntMin);
    check_eq("ovf_hi", hi, 32'd0);

    run_op(MdOpMthi, 32'h0000_0077, 32'd0);
    run_op(MdOpMtlo, 32'd5, 32'd0);
    step(1'b1, MdOpDivu, 32'd9, 32'd0);
    for (int i = 0; i < DivCycles; i++) begin
      step(1'b1, MdOpNone, 32'd0, 32'd0);
      check_eq("dz_busy", 32'(busy), 32'd1);
    end
    step(1'b0, MdOpNone, 32'd0, 32'd0);
    check_eq("dz_busy_end", 32'(busy), 32'd0);
    check_eq("dz_lo", lo, 32'd5);
    check_eq("dz_hi", hi, 32'h0000_0077);

    // Reset in the middle of a DIV window.
    run_op(MdOpMthi, 32'h12, 32'd0);
    step(1'b1, MdOpDiv, 32'd100, 32'd3);
    for (int i = 0; i < 5; i++) step(1'b1, MdOpNone, 32'd0, 32'd0);
    @(negedge clk);
    op_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    model_reset();
    check_eq("mid_rst_busy", 32'(busy), 32'd0);
    check_eq("mid_rst_hi", hi, 32'd0);
    check_eq("mid_rst_lo", lo, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    step(1'b1, MdOpMfhi, 32'd0, 32'd0);
    check_eq("mid_rst_mfhi", rd_val, 32'd0);
    for (int i = 0; i < DivCycles + 2; i++) step(1'b1, MdOpNone, 32'd0, 32'd0);

    // Random traffic, including invalid codes and bubbles.
    for (int n = 0; n < 1500; n++) begin
      logic        v;
      logic [3:0]  op;
      v  = ($urandom_range(0, 4) != 0);
      op = ($urandom_range(0, 2) != 0) ? 4'($urandom_range(1, 8)) : 4'($urandom_range(0, 15));
      step(v, op, rnd_operand(), rnd_operand());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide controller for the execute stage. Accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO/MFHI/MFLO requests alongside the ALU, owns the HI/LO registers, and models the fixed multi-cycle latency of the multiplier and divider with a busy window. While busy, it raises a stall request to the hazard unit so dependent MDU instructions hold in E.

## Interface
- MULT_CYCLES, 5, busy cycles for MULT/MULTU (≥1)
- DIV_CYCLES, 10, busy cycles for DIV/DIVU (≥1)

- clk  in  1  rising-edge clock
- reset  in  1  one clock; reset is asynchronous and active-low
- op_valid  in  1  E-stage instruction is valid (not a bubble)
- md_op  in  4  operation code, values from mdu_pkg
- rs_val  in  32  operand A, forwarded rs
- rt_val  in  32  operand B, forwarded rt
- busy  out  1  multi-cycle operation in flight
- stall_req  out  1  hold the E-stage MDU instruction this cycle
- rd_val  out  32  MFHI/MFLO result, combinational
- hi  out  32  current HI register
- lo  out  32  current LO register

## Operation
- Op codes: NONE=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, MFHI=7, MFLO=8. Codes 9–15 are treated as NONE.
- is_md = op_valid && md_op in 1..8.
- An op is accepted at a clock edge when is_md && !busy. Ops presented while busy are not accepted.
- stall_req = is_md && busy, combinational. No stall is raised on the start cycle itself.
- FSM states:
  - IDLE: on an accepted MULT* or DIV*, latch the computed result into pend_hi/pend_lo, load cnt = MULT_CYCLES-1 or DIV_CYCLES-1, and go to BUSY.
  - BUSY: when cnt==0, commit pend_hi/pend_lo to HI/LO and go to IDLE. Otherwise decrement cnt.
- busy = (state == BUSY).
- MTHI/MTLO: accepted only in IDLE. Write HI or LO with rs_val at the edge; no busy window.
- MFHI/MFLO: rd_val = HI or LO, taken from the register values. Otherwise rd_val = 0. Result is valid only when stall_req is low.
- Arithmetic:
  - MULT: signed 32x32 to 64 bits; HI = upper 32, LO = lower 32.
  - MULTU: same, unsigned.
  - DIV: LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend.
  - DIVU: unsigned quotient and remainder.
- DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Divide by zero (DIV or DIVU): busy window still runs; HI/LO are unchanged at commit.
- Operands are sampled at the accept edge. Later changes to rs_val/rt_val have no effect on the result.

## Timing
- Reset (async, low): state = IDLE, cnt = 0, HI = 0, LO = 0, pend_hi/pend_lo = 0. Outputs: busy = 0, stall_req = 0, rd_val = 0, hi = 0, lo = 0.
- Reset asserted mid-operation: the pending result is discarded and HI/LO are zeroed.
- MULT accepted at edge k: busy is high for cycles k+1..k+MULT_CYCLES. HI/LO update and busy falls at edge k+MULT_CYCLES.
- DIV follows the same rule with DIV_CYCLES.
- An MFLO presented in the first cycle after busy falls reads the new value.
- An MDU op presented in cycle k+1 is stalled until busy falls, then accepted at the next edge. Back-to-back MULTs therefore have MULT_CYCLES+1 cycles between accept edges.
- Non-MDU ops (md_op = NONE, or op_valid = 0) never stall and never disturb BUSY.

## Structure
- mdu_pkg holds:
  - the md_op localparams (4-bit);
  - state encoding IDLE/BUSY;
  - the 0x80000000 constant.
- Sub-module mdu_compute (combinational): takes md_op, rs_val, rt_val and returns res_hi, res_lo and a div_by_zero flag. It isolates the signed/unsigned and overflow rules.
- mdu_ctrl holds the FSM, counter, pending registers and HI/LO.

## Test plan
- Reset low mid-DIV (cnt = 4, HI = 0x12) → busy = 0, HI = LO = 0 immediately. After release, MFHI → rd_val = 0.
- MULT 0xFFFFFFFF × 0x00000002 → busy high for exactly 5 cycles, then HI = 0xFFFFFFFF, LO = 0xFFFFFFFE.
- MULTU with the same operands → HI = 0x00000001, LO = 0xFFFFFFFE.
- DIV −7 / 2 → after 10 cycles LO = 0xFFFFFFFD, HI = 0xFFFFFFFF.
- DIV 0x80000000 / −1 → LO = 0x80000000, HI = 0.
- MTLO 5, then DIVU 9/0 → 10-cycle busy window, then LO = 5 and HI unchanged.
- MULT, then MFLO next cycle → stall_req = 1 for 5 cycles. In the first cycle stall_req = 0, rd_val equals the new LO. A NONE op during busy → stall_req = 0.
